id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register between decode and execute.
- Latches the two register-file read values, the immediate and the control bundle.
- Write-through bypass from the writeback port, so a value written on the same edge is never lost.
- Supports stall (hold), flush (bubble) and an optional load-use hazard interlock; counts inserted bubbles for performance monitoring.

Parameters:
- CTRL_W, 12, width of the opaque execute/memory control bundle.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- id_valid  input  1  decode slot holds a real instruction
- id_rs_address  input  5  rs index
- id_rt_address  input  5  rt index
- id_uses_rt  input  1  instruction reads rt as a source
- id_dest_address  input  5  destination register index
- id_rs_value  input  32  register-file rs read data
- id_rt_value  input  32  register-file rt read data
- id_imm  input  32  sign/zero-extended immediate
- id_ctrl  input  CTRL_W  control bundle
- id_mem_read  input  1  instruction is a load
- id_reg_write  input  1  instruction writes a register
- wb_reg_write  input  1  writeback enable (same signal driving the register file)
- wb_address  input  5  writeback destination
- wb_value  input  32  writeback data
- stall  input  1  downstream hold request
- flush  input  1  squash decode slot (branch/jump redirect)
- ex_valid, ex_rs_address, ex_rt_address, ex_dest_address, ex_rs_value, ex_rt_value, ex_imm, ex_ctrl, ex_mem_read, ex_reg_write  output  widths as the id_* inputs  registered execute-stage copies
- hazard_stall  output  1  load-use interlock; upstream PC/IF/ID must hold
- bubble_count  output  CNT_W  saturating count of inserted bubbles

Behaviour:
- Reset (rst_n low, asynchronous): every ex_* output = 0 and bubble_count = 0; hazard_stall = 0 while reset is held. Reset mid-operation discards the held instruction immediately.
- Latency: 1 cycle from id_* to ex_*.
- Bypass function byp(addr, v) = wb_value if wb_reg_write && wb_address != 0 && wb_address == addr, else v.
  - Register 0 is never bypassed.
- Per-edge priority: reset > flush > stall > hazard > load.
- flush:
  - ex_valid, ex_reg_write and ex_mem_read = 0; all other ex_* fields = 0.
  - bubble_count += 1.
- stall (without flush) = hold:
  - All ex_* fields keep their value, except the hold refresh below.
  - Hold refresh: if ex_valid, ex_rs_value <= byp(ex_rs_address, ex_rs_value); same rule for rt.
  - Held operands never go stale behind a draining writeback.
  - bubble_count unchanged.
- hazard (feature enabled, no stall, no flush):
  - Insert a bubble: same field clearing as flush.
  - bubble_count += 1.
- load:
  - ex_valid <= id_valid.
  - ex_rs_value <= byp(id_rs_address, id_rs_value); ex_rt_value <= byp(id_rt_address, id_rt_value).
  - All other fields copied. If !id_valid, ex_reg_write and ex_mem_read are forced to 0.
- bubble_count saturates at 2^CNT_W-1 and never wraps.
- Flush and hazard in the same cycle: one bubble, bubble_count += 1 once.
- Stall and hazard in the same cycle: hold wins, hazard_stall stays asserted, no count.
- wb write to the register being both read by ID and held in EX: both copies take wb_value on that edge.

Optional Feature:
- Macro: IDEX_LOADUSE_INTERLOCK_EN.
- Defined:
  - hazard_stall = ex_valid && ex_mem_read && ex_dest_address != 0 && id_valid && (ex_dest_address == id_rs_address || (id_uses_rt && ex_dest_address == id_rt_address)).
  - Purely combinational from current state and id_* inputs.
  - A hazard inserts one bubble per cycle while asserted; it clears after the load leaves EX.
- Undefined: hazard_stall tied to 0; no hazard bubbles; bubbles come only from flush.

Test Plan:
- Reset: rst_n low mid-run with ex_valid=1 -> all ex_* = 0 and bubble_count = 0 without waiting for a clock edge.
- Same-edge bypass: id_rs_address=5, id_rs_value=0x11, wb_reg_write=1, wb_address=5, wb_value=0xABCD -> next cycle ex_rs_value=0xABCD; repeat with wb_address=0 -> ex_rs_value=0x11.
- Hold refresh: ex holds rt=7 with value 0x1; stall=1 for 3 cycles, wb writes r7=0x55 in cycle 2 -> ex_rt_value=0x55 after stall; other ex_* unchanged; bubble_count unchanged.
- Flush vs stall: flush=1 and stall=1 on one edge -> ex_valid=0, ex_reg_write=0, bubble_count +1.
- Load-use (macro on): EX holds lw r8 (ex_mem_read=1); ID has add reading rt=8 with id_uses_rt=1 -> hazard_stall=1 and one bubble (ex_valid=0, count +1); next cycle with ID held, hazard_stall=0 and the add loads. With the macro off -> hazard_stall=0 and the add loads immediately.
- Saturation: CNT_W=2, 5 consecutive flushes -> bubble_count = 3 and stays at 3.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg -- ID/EX pipeline register.
//
// Captures the decode-stage operands, immediate and control bundle for the
// execute stage one cycle later. A write-through bypass from the writeback
// port ensures that a register value written on the same clock edge is never
// lost. This applies both when an instruction is being captured and when an
// instruction is being held. The stage supports stall (hold) and flush
// (bubble). It also supports an optional load-use interlock. A saturating
// counter records every bubble that is inserted.
//
// Optional feature macro: IDEX_LOADUSE_INTERLOCK_EN
//   defined   -> hazard_stall detects load-use hazards and inserts bubbles
//   undefined -> hazard_stall is tied low; only flush inserts bubbles
//
// Parameters:
//   CTRL_W  width of the opaque execute/memory control bundle
//   CNT_W   width of the saturating bubble counter
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   id_*                  decode-stage instruction fields and operands
//   wb_reg_write/address/value  writeback port (same as register-file write)
//   stall                 downstream hold request
//   flush                 squash decode slot (branch/jump redirect)
//   ex_*                  registered execute-stage copies of id_*
//   hazard_stall          load-use interlock, upstream PC/IF/ID must hold
//   bubble_count          saturating count of inserted bubbles
module id_ex_stage_reg #(
  parameter int CTRL_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [4:0]        id_rs_address,
  input  logic [4:0]        id_rt_address,
  input  logic              id_uses_rt,
  input  logic [4:0]        id_dest_address,
  input  logic [31:0]       id_rs_value,
  input  logic [31:0]       id_rt_value,
  input  logic [31:0]       id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_mem_read,
  input  logic              id_reg_write,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_address,
  input  logic [31:0]       wb_value,
  input  logic              stall,
  input  logic              flush,
  output logic              ex_valid,
  output logic [4:0]        ex_rs_address,
  output logic [4:0]        ex_rt_address,
  output logic [4:0]        ex_dest_address,
  output logic [31:0]       ex_rs_value,
  output logic [31:0]       ex_rt_value,
  output logic [31:0]       ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_mem_read,
  output logic              ex_reg_write,
  output logic              hazard_stall,
  output logic [CNT_W-1:0]  bubble_count
);

  logic        hazard;
  logic        insert_bubble;
  logic        wb_live;
  logic [31:0] byp_id_rs;
  logic [31:0] byp_id_rt;
  logic [31:0] byp_ex_rs;
  logic [31:0] byp_ex_rt;

`ifdef IDEX_LOADUSE_INTERLOCK_EN
  // A load in EX whose destination feeds a source of the instruction in ID.
  always_comb begin
    hazard = 1'b0;
    if (ex_valid && ex_mem_read && (ex_dest_address != 5'd0) && id_valid) begin
      hazard = (ex_dest_address == id_rs_address) ||
               (id_uses_rt && (ex_dest_address == id_rt_address));
    end
  end
`else
  logic unused_uses_rt;
  assign unused_uses_rt = id_uses_rt;
  always_comb hazard = 1'b0;
`endif

  assign hazard_stall = hazard;

  // Flush beats stall. A hazard only produces a bubble when the stage is not
  // being held. When flush and hazard occur together, a single bubble is
  // inserted.
  assign insert_bubble = flush || (!stall && hazard);

  // Register 0 is hardwired, so a write to it is never forwarded.
  assign wb_live = wb_reg_write && (wb_address != 5'd0);

  always_comb begin
    byp_id_rs = (wb_live && (wb_address == id_rs_address)) ? wb_value : id_rs_value;
    byp_id_rt = (wb_live && (wb_address == id_rt_address)) ? wb_value : id_rt_value;
    byp_ex_rs = (wb_live && (wb_address == ex_rs_address)) ? wb_value : ex_rs_value;
    byp_ex_rt = (wb_live && (wb_address == ex_rt_address)) ? wb_value : ex_rt_value;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid        <= 1'b0;
      ex_rs_address   <= '0;
      ex_rt_address   <= '0;
      ex_dest_address <= '0;
      ex_rs_value     <= '0;
      ex_rt_value     <= '0;
      ex_imm          <= '0;
      ex_ctrl         <= '0;
      ex_mem_read     <= 1'b0;
      ex_reg_write    <= 1'b0;
    end else if (insert_bubble) begin
      ex_valid        <= 1'b0;
      ex_rs_address   <= '0;
      ex_rt_address   <= '0;
      ex_dest_address <= '0;
      ex_rs_value     <= '0;
      ex_rt_value     <= '0;
      ex_imm          <= '0;
      ex_ctrl         <= '0;
      ex_mem_read     <= 1'b0;
      ex_reg_write    <= 1'b0;
    end else if (stall) begin
      // A held instruction keeps its fields. Its operands still absorb a
      // draining writeback, so they cannot go stale while the stage is held.
      if (ex_valid) begin
        ex_rs_value <= byp_ex_rs;
        ex_rt_value <= byp_ex_rt;
      end
    end else begin
      ex_valid        <= id_valid;
      ex_rs_address   <= id_rs_address;
      ex_rt_address   <= id_rt_address;
      ex_dest_address <= id_dest_address;
      ex_rs_value     <= byp_id_rs;
      ex_rt_value     <= byp_id_rt;
      ex_imm          <= id_imm;
      ex_ctrl         <= id_ctrl;
      ex_mem_read     <= id_valid && id_mem_read;
      ex_reg_write    <= id_valid && id_reg_write;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_count <= '0;
    end else if (insert_bubble && (bubble_count != '1)) begin
      bubble_count <= bubble_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Testbench for id_ex_stage_reg. It combines vector-table checks,
// hand-written multi-cycle sequences and randomized traffic. The randomized
// traffic is compared against a behavioural model of the stage.
module tb_id_ex_stage_reg;

  localparam int CTRL_W = 12;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, rst_n_s;
  logic              id_valid, id_uses_rt, id_mem_read, id_reg_write;
  logic [4:0]        id_rs_address, id_rt_address, id_dest_address;
  logic [31:0]       id_rs_value, id_rt_value, id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic              wb_reg_write;
  logic [4:0]        wb_address;
  logic [31:0]       wb_value;
  logic              stall, flush;

  logic              ex_valid, ex_mem_read, ex_reg_write, hazard_stall;
  logic [4:0]        ex_rs_address, ex_rt_address, ex_dest_address;
  logic [31:0]       ex_rs_value, ex_rt_value, ex_imm;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CNT_W-1:0]  bubble_count;

  // second instance with a narrow counter, used for saturation
  logic              unused_s_valid, unused_s_mr, unused_s_rw, unused_s_haz;
  logic [4:0]        unused_s_rs, unused_s_rt, unused_s_dest;
  logic [31:0]       unused_s_rsv, unused_s_rtv, unused_s_imm;
  logic [CTRL_W-1:0] unused_s_ctrl;
  logic [1:0]        bubble_count_s;

  id_ex_stage_reg #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs_address(id_rs_address), .id_rt_address(id_rt_address),
    .id_uses_rt(id_uses_rt), .id_dest_address(id_dest_address),
    .id_rs_value(id_rs_value), .id_rt_value(id_rt_value), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .id_mem_read(id_mem_read), .id_reg_write(id_reg_write),
    .wb_reg_write(wb_reg_write), .wb_address(wb_address), .wb_value(wb_value),
    .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_rs_address(ex_rs_address), .ex_rt_address(ex_rt_address),
    .ex_dest_address(ex_dest_address), .ex_rs_value(ex_rs_value), .ex_rt_value(ex_rt_value),
    .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .ex_mem_read(ex_mem_read),
    .ex_reg_write(ex_reg_write), .hazard_stall(hazard_stall), .bubble_count(bubble_count)
  );

  id_ex_stage_reg #(.CTRL_W(CTRL_W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n_s),
    .id_valid(id_valid), .id_rs_address(id_rs_address), .id_rt_address(id_rt_address),
    .id_uses_rt(id_uses_rt), .id_dest_address(id_dest_address),
    .id_rs_value(id_rs_value), .id_rt_value(id_rt_value), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .id_mem_read(id_mem_read), .id_reg_write(id_reg_write),
    .wb_reg_write(wb_reg_write), .wb_address(wb_address), .wb_value(wb_value),
    .stall(stall), .flush(flush),
    .ex_valid(unused_s_valid), .ex_rs_address(unused_s_rs), .ex_rt_address(unused_s_rt),
    .ex_dest_address(unused_s_dest), .ex_rs_value(unused_s_rsv), .ex_rt_value(unused_s_rtv),
    .ex_imm(unused_s_imm), .ex_ctrl(unused_s_ctrl), .ex_mem_read(unused_s_mr),
    .ex_reg_write(unused_s_rw), .hazard_stall(unused_s_haz), .bubble_count(bubble_count_s)
  );

`ifdef IDEX_LOADUSE_INTERLOCK_EN
  localparam bit HAZ_ON = 1'b1;
`else
  localparam bit HAZ_ON = 1'b0;
`endif

  int unsigned passed = 0;
  int unsigned total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    else passed++;
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic              valid;
    logic [4:0]        rs, rt, dest;
    logic [31:0]       rsv, rtv, imm;
    logic [CTRL_W-1:0] ctrl;
    logic              mr, rw;
  } ex_t;

  ex_t         m;
  int unsigned mcnt;

  function automatic logic [31:0] byp_m(input logic [4:0] a, input logic [31:0] v);
    if (wb_reg_write && wb_address != 5'd0 && wb_address == a) return wb_value;
    return v;
  endfunction

  function automatic logic haz_m();
    if (!HAZ_ON) return 1'b0;
    return m.valid && m.mr && m.dest != 5'd0 && id_valid &&
           (m.dest == id_rs_address || (id_uses_rt && m.dest == id_rt_address));
  endfunction

  // Advance one clock. The model's next state is taken from the inputs
  // present at the edge.
  task automatic step();
    ex_t n;
    int unsigned c;
    n = m;
    c = mcnt;
    if (flush || (!stall && haz_m())) begin
      n = '0;
      if (c < 65535) c++;
    end else if (stall) begin
      if (m.valid) begin
        n.rsv = byp_m(m.rs, m.rsv);
        n.rtv = byp_m(m.rt, m.rtv);
      end
    end else begin
      n.valid = id_valid;
      n.rs    = id_rs_address;
      n.rt    = id_rt_address;
      n.dest  = id_dest_address;
      n.rsv   = byp_m(id_rs_address, id_rs_value);
      n.rtv   = byp_m(id_rt_address, id_rt_value);
      n.imm   = id_imm;
      n.ctrl  = id_ctrl;
      n.mr    = id_valid & id_mem_read;
      n.rw    = id_valid & id_reg_write;
    end
    @(posedge clk);
    #1;
    m    = n;
    mcnt = c;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, ex_valid, m.valid);
    chk({tag, ".rs"}, ex_rs_address, m.rs);
    chk({tag, ".rt"}, ex_rt_address, m.rt);
    chk({tag, ".dest"}, ex_dest_address, m.dest);
    chk({tag, ".rsv"}, ex_rs_value, m.rsv);
    chk({tag, ".rtv"}, ex_rt_value, m.rtv);
    chk({tag, ".imm"}, ex_imm, m.imm);
    chk({tag, ".ctrl"}, ex_ctrl, m.ctrl);
    chk({tag, ".mr"}, ex_mem_read, m.mr);
    chk({tag, ".rw"}, ex_reg_write, m.rw);
    chk({tag, ".cnt"}, bubble_count, mcnt);
  endtask

  task automatic idle();
    id_valid = 0; id_uses_rt = 0; id_mem_read = 0; id_reg_write = 0;
    id_rs_address = 0; id_rt_address = 0; id_dest_address = 0;
    id_rs_value = 0; id_rt_value = 0; id_imm = 0; id_ctrl = 0;
    wb_reg_write = 0; wb_address = 0; wb_value = 0; stall = 0; flush = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        v;
    logic [4:0]  rs, rt, dst;
    logic [31:0] rsv, rtv;
    logic        mr, rw, wbw;
    logic [4:0]  wba;
    logic [31:0] wbv;
    logic        fl, st;
    logic        e_v;
    logic [31:0] e_rsv, e_rtv;
    logic        e_mr, e_rw;
    int unsigned inc;
  } vec_t;

  function automatic vec_t mk(
      logic v, logic [4:0] rs, logic [4:0] rt, logic [4:0] dst,
      logic [31:0] rsv, logic [31:0] rtv, logic mr, logic rw,
      logic wbw, logic [4:0] wba, logic [31:0] wbv, logic fl, logic st,
      logic e_v, logic [31:0] e_rsv, logic [31:0] e_rtv, logic e_mr, logic e_rw,
      int unsigned inc);
    vec_t r;
    r.v = v; r.rs = rs; r.rt = rt; r.dst = dst; r.rsv = rsv; r.rtv = rtv;
    r.mr = mr; r.rw = rw; r.wbw = wbw; r.wba = wba; r.wbv = wbv; r.fl = fl; r.st = st;
    r.e_v = e_v; r.e_rsv = e_rsv; r.e_rtv = e_rtv; r.e_mr = e_mr; r.e_rw = e_rw; r.inc = inc;
    return r;
  endfunction

  vec_t        tv[9];
  int unsigned exp_cnt;
  int unsigned cnt0;

  initial begin
    tv[0] = mk(1, 5, 6, 4, 32'h11, 32'h22, 0, 1, 1, 5, 32'hABCD, 0, 0,  1, 32'hABCD, 32'h22, 0, 1, 0);
    tv[1] = mk(1, 5, 6, 4, 32'h11, 32'h22, 0, 1, 1, 0, 32'hABCD, 0, 0,  1, 32'h11,   32'h22, 0, 1, 0);
    tv[2] = mk(1, 0, 6, 4, 32'h77, 32'h22, 0, 1, 1, 0, 32'hABCD, 0, 0,  1, 32'h77,   32'h22, 0, 1, 0);
    tv[3] = mk(1, 9, 9, 2, 32'h2,  32'h1,  0, 0, 1, 9, 32'h900D, 0, 0,  1, 32'h900D, 32'h900D, 0, 0, 0);
    tv[4] = mk(1, 9, 9, 2, 32'h2,  32'h1,  0, 0, 0, 9, 32'h900D, 0, 0,  1, 32'h2,    32'h1,  0, 0, 0);
    tv[5] = mk(0, 3, 4, 6, 32'h33, 32'h44, 1, 1, 0, 0, 32'h0,    0, 0,  0, 32'h33,   32'h44, 0, 0, 0);
    tv[6] = mk(1, 3, 4, 6, 32'h33, 32'h44, 0, 1, 1, 3, 32'h5,    1, 0,  0, 32'h0,    32'h0,  0, 0, 1);
    tv[7] = mk(1, 3, 4, 6, 32'h33, 32'h44, 0, 1, 0, 0, 32'h0,    1, 1,  0, 32'h0,    32'h0,  0, 0, 1);
    tv[8] = mk(1, 1, 2, 3, 32'h55, 32'h66, 1, 1, 0, 0, 32'h0,    0, 0,  1, 32'h55,   32'h66, 1, 1, 0);

    idle();
    rst_n = 0; rst_n_s = 0;
    m = '0; mcnt = 0; exp_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset.hazard", hazard_stall, 0);
    @(negedge clk);
    rst_n = 1; rst_n_s = 1;
    @(posedge clk);
    #1;

    // ---- table ----
    for (int i = 0; i < 9; i++) begin
      idle();
      id_valid = tv[i].v; id_rs_address = tv[i].rs; id_rt_address = tv[i].rt;
      id_dest_address = tv[i].dst; id_rs_value = tv[i].rsv; id_rt_value = tv[i].rtv;
      id_mem_read = tv[i].mr; id_reg_write = tv[i].rw;
      id_imm = 32'h1000 + i; id_ctrl = CTRL_W'(i + 1);
      wb_reg_write = tv[i].wbw; wb_address = tv[i].wba; wb_value = tv[i].wbv;
      flush = tv[i].fl; stall = tv[i].st;
      step();
      exp_cnt += tv[i].inc;
      chk($sformatf("vec%0d.valid", i), ex_valid, tv[i].e_v);
      chk($sformatf("vec%0d.rsv", i), ex_rs_value, tv[i].e_rsv);
      chk($sformatf("vec%0d.rtv", i), ex_rt_value, tv[i].e_rtv);
      chk($sformatf("vec%0d.mr", i), ex_mem_read, tv[i].e_mr);
      chk($sformatf("vec%0d.rw", i), ex_reg_write, tv[i].e_rw);
      chk($sformatf("vec%0d.imm", i), ex_imm, tv[i].fl ? 32'h0 : 32'h1000 + i);
      chk($sformatf("vec%0d.dest", i), ex_dest_address, tv[i].fl ? 5'd0 : tv[i].dst);
      chk($sformatf("vec%0d.cnt", i), bubble_count, exp_cnt);
    end

    // ---- hold refresh: wb to held rt during a 3-cycle stall ----
    idle();
    id_valid = 1; id_rs_address = 2; id_rs_value = 32'h33; id_rt_address = 7;
    id_rt_value = 32'h1; id_dest_address = 9; id_imm = 32'h1234; id_ctrl = 12'h05A;
    id_reg_write = 1;
    step();
    cnt0 = exp_cnt;
    idle();
    id_valid = 1; id_rt_address = 7; id_rt_value = 32'hDEAD; id_dest_address = 17;
    stall = 1;
    step();
    wb_reg_write = 1; wb_address = 7; wb_value = 32'h55;
    step();
    wb_reg_write = 0; wb_value = 0;
    step();
    chk("hold.rtv", ex_rt_value, 32'h55);
    chk("hold.rsv", ex_rs_value, 32'h33);
    chk("hold.dest", ex_dest_address, 9);
    chk("hold.imm", ex_imm, 32'h1234);
    chk("hold.ctrl", ex_ctrl, 12'h05A);
    chk("hold.valid", ex_valid, 1);
    chk("hold.cnt", bubble_count, cnt0);

    // ---- flush and stall on the same edge ----
    flush = 1; stall = 1;
    step();
    exp_cnt++;
    chk("flushstall.valid", ex_valid, 0);
    chk("flushstall.rw", ex_reg_write, 0);
    chk("flushstall.cnt", bubble_count, exp_cnt);

    // ---- load-use: lw r8 then add reading rt=8 ----
    idle();
    id_valid = 1; id_dest_address = 8; id_mem_read = 1; id_reg_write = 1; id_rs_address = 1;
    step();
    idle();
    id_valid = 1; id_rs_address = 2; id_rt_address = 8; id_uses_rt = 1;
    id_dest_address = 10; id_reg_write = 1; id_rt_value = 32'hAA;
    #1;
    chk("loaduse.hazard", hazard_stall, HAZ_ON);
    step();
    if (HAZ_ON) begin
      exp_cnt++;
      chk("loaduse.bubble_valid", ex_valid, 0);
      chk("loaduse.bubble_cnt", bubble_count, exp_cnt);
      chk("loaduse.hazard_clear", hazard_stall, 0);
      step();
    end
    chk("loaduse.add_valid", ex_valid, 1);
    chk("loaduse.add_rt", ex_rt_address, 8);
    chk("loaduse.add_dest", ex_dest_address, 10);
    chk("loaduse.cnt", bubble_count, exp_cnt);

    // lw r8 followed by a reader that does not use rt: no interlock
    idle();
    id_valid = 1; id_dest_address = 8; id_mem_read = 1;
    step();
    idle();
    id_valid = 1; id_rs_address = 3; id_rt_address = 8; id_uses_rt = 0;
    #1;
    chk("loaduse.no_rt_use", hazard_stall, 0);
    id_rs_address = 8;
    #1;
    chk("loaduse.rs_use", hazard_stall, HAZ_ON);
    step();

    // ---- saturation on the narrow counter ----
    idle();
    @(negedge clk);
    rst_n_s = 0;
    #1;
    rst_n_s = 1;
    chk("sat.reset", bubble_count_s, 0);
    for (int i = 1; i <= 5; i++) begin
      flush = 1;
      step();
      chk($sformatf("sat.flush%0d", i), bubble_count_s, (i > 3) ? 3 : i);
    end
    idle();
    step();
    step();
    chk("sat.hold", bubble_count_s, 3);

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 400; i++) begin
      id_valid = ($urandom_range(0, 4) != 0);
      id_rs_address = 5'($urandom_range(0, 7));
      id_rt_address = 5'($urandom_range(0, 7));
      id_dest_address = 5'($urandom_range(0, 7));
      id_uses_rt = $urandom_range(0, 1) != 0;
      id_rs_value = $urandom;
      id_rt_value = $urandom;
      id_imm = $urandom;
      id_ctrl = CTRL_W'($urandom);
      id_mem_read = ($urandom_range(0, 2) == 0);
      id_reg_write = $urandom_range(0, 1) != 0;
      wb_reg_write = $urandom_range(0, 1) != 0;
      wb_address = 5'($urandom_range(0, 7));
      wb_value = $urandom;
      flush = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 3) == 0);
      #1;
      chk($sformatf("rnd%0d.hazard", i), hazard_stall, haz_m());
      step();
      check_all($sformatf("rnd%0d", i));
    end

    // ---- asynchronous reset mid-run ----
    idle();
    id_valid = 1; id_rs_address = 4; id_rs_value = 32'h1234; id_dest_address = 6;
    id_reg_write = 1;
    step();
    chk("areset.pre_valid", ex_valid, 1);
    #2;
    rst_n = 0;
    #1;
    m = '0;
    mcnt = 0;
    check_all("areset");
    chk("areset.hazard", hazard_stall, 0);
    @(negedge clk);
    rst_n = 1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
